// File: rtl/apa102_ws2812_bridge_core_if.sv
// Pin-level bundle between the APA102 input pins and the WS2812 output side of the bridge.
// The bridge core takes the slave view.
interface apa102_ws2812_bridge_core_if;
   logic sck;
   logic sda;
   logic led_o;
   logic busy;
   logic frame_ok;
   logic overrun;

   modport master (
      output sck, sda,
      input  led_o, busy, frame_ok, overrun
   );

   modport slave (
      input  sck, sda,
      output led_o, busy, frame_ok, overrun
   );
endinterface

// File: rtl/apa102_ws2812_bridge_core.sv
// APA102 frame decoder with brightness scaling, double-buffered into a WS2812 bit serialiser.
// The shadow buffer fills from the SPI side; a full frame is copied to display only while idle.
module apa102_ws2812_bridge_core #(
   parameter int unsigned LED_CNT   = 7,
   parameter int unsigned T0H       = 8,
   parameter int unsigned T1H       = 16,
   parameter int unsigned TBIT      = 25,
   parameter int unsigned TRESET    = 1200,
   parameter int unsigned OUT_ORDER = 0
) (
   input  logic                          clk,
   input  logic                          reset,
   apa102_ws2812_bridge_core_if.slave    bus
);

   localparam int unsigned IW   = $clog2(LED_CNT + 1);
   localparam int unsigned PW   = (LED_CNT > 1) ? $clog2(LED_CNT) : 1;
   localparam int unsigned TMAX = (TBIT > TRESET) ? TBIT : TRESET;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   localparam logic [IW-1:0] IDX_LAST = IW'(LED_CNT - 1);
   localparam logic [IW-1:0] IDX_FULL = IW'(LED_CNT);
   localparam logic [PW-1:0] PIX_LAST = PW'(LED_CNT - 1);
   localparam logic [TW-1:0] T0_LAST  = TW'(T0H - 1);
   localparam logic [TW-1:0] T1_LAST  = TW'(T1H - 1);
   localparam logic [TW-1:0] TB_LAST  = TW'(TBIT - 1);
   localparam logic [TW-1:0] TR_LAST  = TW'(TRESET - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_HIGH  = 3'd2;
   localparam logic [2:0] S_LOW   = 3'd3;
   localparam logic [2:0] S_LATCH = 3'd4;

   logic          sck_s1_q, sck_s2_q, sck_s3_q;
   logic          sda_s1_q, sda_s2_q;
   logic          sck_rise;

   logic [31:0]   sr_q, sr_d;
   logic [4:0]    cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic          pend_q, pend_d;
   logic          pvld_q, pvld_d;
   logic [28:0]   pword_q, pword_d;
   logic          ovr_d;
   logic          commit;
   logic [23:0]   pix_scaled;

   logic [23:0]   shadow_q  [LED_CNT];
   logic [23:0]   display_q [LED_CNT];

   logic [2:0]    state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [PW-1:0] pix_q, pix_d;
   logic [4:0]    bit_q, bit_d;
   logic [23:0]   sh_q, sh_d;
   logic [23:0]   disp_px, load_word;

   logic          led_q, busy_q, fok_q, ovr_q;

   function automatic logic [7:0] scale(input logic [7:0] c, input logic [4:0] b);
      logic [12:0] prod;
      prod = {5'b0, c} * {8'b0, b};
      return (b == 5'd31) ? c : prod[12:5];
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sck_s1_q <= 1'b0;
         sck_s2_q <= 1'b0;
         sck_s3_q <= 1'b0;
         sda_s1_q <= 1'b0;
         sda_s2_q <= 1'b0;
      end else begin
         sck_s1_q <= bus.sck;
         sck_s2_q <= sck_s1_q;
         sck_s3_q <= sck_s2_q;
         sda_s1_q <= bus.sda;
         sda_s2_q <= sda_s1_q;
      end
   end

   assign sck_rise = sck_s2_q & ~sck_s3_q;
   assign commit   = (state_q == S_IDLE) && pend_q;

   // An all-zero window is a start frame regardless of bit alignment; a commit in the
   // same cycle has already claimed the pending frame, so that case is not an overrun.
   always_comb begin
      sr_d    = sr_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      pvld_d  = 1'b0;
      pword_d = pword_q;
      ovr_d   = 1'b0;
      if (pvld_q) begin
         idx_d = idx_q + IW'(1);
         if (idx_q == IDX_LAST) pend_d = 1'b1;
      end
      if (commit) pend_d = 1'b0;
      if (sck_rise) begin
         sr_d  = {sr_q[30:0], sda_s2_q};
         cnt_d = cnt_q + 5'd1;
         if (sr_d == '0) begin
            cnt_d  = '0;
            idx_d  = '0;
            pend_d = 1'b0;
            ovr_d  = pend_q & ~commit;
         end else if (cnt_q == 5'd31 && sr_d[31:29] == 3'b111 && idx_q < IDX_FULL) begin
            pvld_d  = 1'b1;
            pword_d = sr_d[28:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q    <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         pend_q  <= 1'b0;
         pvld_q  <= 1'b0;
         pword_q <= '0;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         pvld_q  <= pvld_d;
         pword_q <= pword_d;
      end
   end

   // Buffers hold {R,G,B}; wire order is chosen at load time.
   assign pix_scaled = {scale(pword_q[7:0],   pword_q[28:24]),
                        scale(pword_q[15:8],  pword_q[28:24]),
                        scale(pword_q[23:16], pword_q[28:24])};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < LED_CNT; i++) shadow_q[i] <= '0;
      end else if (pvld_q) begin
         shadow_q[idx_q[PW-1:0]] <= pix_scaled;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < LED_CNT; i++) display_q[i] <= '0;
      end else if (commit) begin
         for (int unsigned i = 0; i < LED_CNT; i++) display_q[i] <= shadow_q[i];
      end
   end

   assign disp_px   = display_q[pix_q];
   assign load_word = (OUT_ORDER == 0) ? {disp_px[15:8], disp_px[23:16], disp_px[7:0]} : disp_px;

   // LOAD is the first high cycle of a pixel's bit 0, so the bit timer never pauses.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      pix_d   = pix_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      case (state_q)
         S_IDLE: begin
            if (pend_q) begin
               state_d = S_LOAD;
               tmr_d   = '0;
               pix_d   = '0;
            end
         end
         S_LOAD: begin
            sh_d    = load_word;
            bit_d   = '0;
            tmr_d   = tmr_q + TW'(1);
            state_d = S_HIGH;
         end
         S_HIGH: begin
            tmr_d = tmr_q + TW'(1);
            if (tmr_q == (sh_q[23] ? T1_LAST : T0_LAST)) state_d = S_LOW;
         end
         S_LOW: begin
            if (tmr_q == TB_LAST) begin
               tmr_d = '0;
               if (bit_q == 5'd23) begin
                  if (pix_q == PIX_LAST) begin
                     state_d = S_LATCH;
                  end else begin
                     pix_d   = pix_q + PW'(1);
                     state_d = S_LOAD;
                  end
               end else begin
                  bit_d   = bit_q + 5'd1;
                  sh_d    = {sh_q[22:0], 1'b0};
                  state_d = S_HIGH;
               end
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_LATCH: begin
            if (tmr_q == TR_LAST) begin
               tmr_d   = '0;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         pix_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         fok_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         pix_q   <= pix_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         led_q   <= (state_d == S_LOAD) || (state_d == S_HIGH);
         busy_q  <= (state_d != S_IDLE);
         fok_q   <= commit;
         ovr_q   <= ovr_d;
      end
   end

   assign bus.led_o    = led_q;
   assign bus.busy     = busy_q;
   assign bus.frame_ok = fok_q;
   assign bus.overrun  = ovr_q;

endmodule

// File: tb/tb_apa102_ws2812_bridge_core.sv
// Bench for the APA102 to WS2812 bridge: random frames over SPI, decoded WS2812 streams
// compared against an arithmetic model, for both GRB and RGB wire orders.
module tb_apa102_ws2812_bridge_core;

   localparam int NLED   = 7;
   localparam int PT0H   = 8;
   localparam int PT1H   = 16;
   localparam int PTBIT  = 25;
   localparam int PTRST  = 1200;
   localparam int STREAM = NLED * 24 * PTBIT + PTRST;
   localparam int PXW    = NLED * 24;

   typedef struct packed {
      int unsigned     len;
      logic            shape_ok;
      logic [PXW-1:0]  px;
   } frame_t;

   logic clk = 1'b0;
   logic reset;

   apa102_ws2812_bridge_core_if bus0 ();
   apa102_ws2812_bridge_core_if bus1 ();

   assign bus1.sck = bus0.sck;
   assign bus1.sda = bus0.sda;

   apa102_ws2812_bridge_core #(
      .LED_CNT(NLED), .T0H(PT0H), .T1H(PT1H), .TBIT(PTBIT), .TRESET(PTRST), .OUT_ORDER(0)
   ) dut_grb (
      .clk(clk), .reset(reset), .bus(bus0)
   );

   apa102_ws2812_bridge_core #(
      .LED_CNT(NLED), .T0H(PT0H), .T1H(PT1H), .TBIT(PTBIT), .TRESET(PTRST), .OUT_ORDER(1)
   ) dut_rgb (
      .clk(clk), .reset(reset), .bus(bus1)
   );

   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_fail   = 0;
   frame_t fq0[$];
   frame_t fq1[$];
   logic   led_w  [2];
   logic   busy_w [2];

   assign led_w[0]  = bus0.led_o;
   assign led_w[1]  = bus1.led_o;
   assign busy_w[0] = bus0.busy;
   assign busy_w[1] = bus1.busy;

   int cyc = 0, fok_cnt = 0, ovr_cnt = 0, busy_cnt = 0, led_cnt = 0, rise_cyc = 0;
   logic busy_prev = 1'b0;

   always @(negedge clk) begin
      cyc++;
      if (bus0.frame_ok) fok_cnt++;
      if (bus0.overrun)  ovr_cnt++;
      if (bus0.busy)     busy_cnt++;
      if (bus0.led_o)    led_cnt++;
      if (bus0.busy && !busy_prev) rise_cyc = cyc;
      busy_prev = bus0.busy;
   end

   // Record led_o over each busy window, then decode pulse widths into wire bits.
   for (genvar g = 0; g < 2; g++) begin : g_cap
      bit cur[$];
      always @(negedge clk) begin
         frame_t f;
         int h;
         if (reset) begin
            cur.delete();
         end else if (busy_w[g]) begin
            cur.push_back(led_w[g]);
         end else if (cur.size() != 0) begin
            f.len = cur.size();
            f.shape_ok = 1'b1;
            f.px = '0;
            for (int k = 0; k < PXW; k++) begin
               if ((k + 1) * PTBIT > cur.size()) begin
                  f.shape_ok = 1'b0;
                  break;
               end
               h = 0;
               while (h < PTBIT && cur[k * PTBIT + h]) h++;
               for (int j = h; j < PTBIT; j++) if (cur[k * PTBIT + j]) f.shape_ok = 1'b0;
               if (h == PT1H) f.px[PXW - 1 - k] = 1'b1;
               else if (h != PT0H) f.shape_ok = 1'b0;
            end
            for (int j = PXW * PTBIT; j < cur.size(); j++) if (cur[j]) f.shape_ok = 1'b0;
            if (g == 0) fq0.push_back(f);
            else        fq1.push_back(f);
            cur.delete();
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int scale(input int c, input int b);
      return (b == 31) ? c : (c * b) / 32;
   endfunction

   // First NLED words with a 111 header become pixels; anything else is skipped.
   function automatic logic [PXW-1:0] model(input logic [31:0] w[$], input bit rgb);
      logic [PXW-1:0] r;
      logic [31:0] x;
      int n, b, rr, gg, bb;
      r = '0;
      n = 0;
      for (int i = 0; i < w.size(); i++) begin
         x = w[i];
         if (x[31:29] == 3'b111 && n < NLED) begin
            b  = int'(x[28:24]);
            bb = scale(int'(x[23:16]), b);
            gg = scale(int'(x[15:8]), b);
            rr = scale(int'(x[7:0]), b);
            r[PXW - 1 - 24 * n -: 24] = rgb ? {8'(rr), 8'(gg), 8'(bb)} : {8'(gg), 8'(rr), 8'(bb)};
            n++;
         end
      end
      return r;
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk) bus0.sda = b;
      @(negedge clk) bus0.sck = 1'b1;
      repeat (3) @(negedge clk);
      bus0.sck = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) send_bit(w[i]);
   endtask

   task automatic send_frame(input logic [31:0] px[$], input bit with_end);
      send_word(32'h0);
      foreach (px[i]) send_word(px[i]);
      if (with_end) send_word(32'hFFFF_FFFF);
   endtask

   task automatic wait_frames(input int target);
      int t = 0;
      while ((fq0.size() < target || fq1.size() < target) && t < 40000) begin
         @(negedge clk);
         t++;
      end
      check("frames_grb", 64'(fq0.size()), 64'(target));
      check("frames_rgb", 64'(fq1.size()), 64'(target));
   endtask

   task automatic wait_busy();
      int t = 0;
      while (!bus0.busy && t < 20000) begin
         @(negedge clk);
         t++;
      end
      check("busy_rise", 64'(bus0.busy), 64'd1);
      @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input frame_t f, input logic [PXW-1:0] exp);
      check({tag, "_len"}, 64'(f.len), 64'(STREAM));
      check({tag, "_shape"}, 64'(f.shape_ok), 64'd1);
      for (int k = 0; k < NLED; k++)
         check($sformatf("%s_px%0d", tag, k), 64'(f.px[PXW - 1 - 24 * k -: 24]),
               64'(exp[PXW - 1 - 24 * k -: 24]));
   endtask

   task automatic check_both(input string tag, input int idx, input logic [31:0] w[$]);
      if (fq0.size() > idx && fq1.size() > idx) begin
         check_frame({tag, "_grb"}, fq0[idx], model(w, 1'b0));
         check_frame({tag, "_rgb"}, fq1[idx], model(w, 1'b1));
      end else begin
         check({tag, "_frame_present"}, 64'(fq0.size()), 64'(idx + 1));
      end
   endtask

   function automatic void rand_frame(output logic [31:0] q[$]);
      q.delete();
      for (int i = 0; i < NLED; i++) q.push_back({3'b111, 5'($urandom), 24'($urandom)});
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] txq[$];
      logic [31:0] txb[$];
      int nf, b_fok, b_ovr, b_busy, b_fq, tgt, t;

      reset = 1'b1;
      bus0.sck = 1'b0;
      bus0.sda = 1'b0;

      // Reset held while the SPI pins toggle randomly.
      repeat (60) begin
         @(negedge clk);
         bus0.sck = 1'($urandom);
         bus0.sda = 1'($urandom);
      end
      check("rst_led", 64'(bus0.led_o), 64'd0);
      check("rst_busy", 64'(bus0.busy), 64'd0);
      check("rst_frame_ok", 64'(bus0.frame_ok), 64'd0);
      check("rst_overrun", 64'(bus0.overrun), 64'd0);
      check("rst_led_cycles", 64'(led_cnt), 64'd0);
      check("rst_busy_cycles", 64'(busy_cnt), 64'd0);
      check("rst_pulses", 64'(fok_cnt + ovr_cnt), 64'd0);
      bus0.sck = 1'b0;
      bus0.sda = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      nf = 0;

      // Full-brightness red on every pixel.
      txq.delete();
      repeat (NLED) txq.push_back(32'hFF00_00FF);
      b_fok = fok_cnt;
      b_ovr = ovr_cnt;
      send_frame(txq, 1'b1);
      nf++;
      wait_frames(nf);
      check_both("red", nf - 1, txq);
      if (fq0.size() >= nf) check("red_grb_px0", 64'(fq0[nf-1].px[PXW-1 -: 24]), 64'h00FF00);
      if (fq1.size() >= nf) check("red_rgb_byte0", 64'(fq1[nf-1].px[PXW-1 -: 8]), 64'hFF);
      check("red_frame_ok", 64'(fok_cnt - b_fok), 64'd1);
      check("red_overrun", 64'(ovr_cnt - b_ovr), 64'd0);

      // Half brightness, zero brightness, random pixels and one ignored header.
      txq.delete();
      txq.push_back(32'hF080_8080);
      txq.push_back(32'hE0FF_FFFF);
      txq.push_back({3'b111, 5'($urandom), 24'($urandom)});
      txq.push_back({3'b110, 29'($urandom)});
      repeat (NLED - 3) txq.push_back({3'b111, 5'($urandom), 24'($urandom)});
      send_frame(txq, 1'b1);
      nf++;
      wait_frames(nf);
      check_both("scale", nf - 1, txq);
      if (fq0.size() >= nf) begin
         check("half_px0", 64'(fq0[nf-1].px[PXW-1 -: 24]), 64'h404040);
         check("zero_px1", 64'(fq0[nf-1].px[PXW-25 -: 24]), 64'h000000);
      end

      // Misaligned junk bits ahead of the start frame.
      repeat (5) send_bit(1'($urandom));
      txq.delete();
      repeat (NLED) txq.push_back(32'hFF00_00FF);
      send_frame(txq, 1'b1);
      nf++;
      wait_frames(nf);
      check_both("junk", nf - 1, txq);

      // Frame B completes while A streams and follows it after the latch gap.
      rand_frame(txq);
      rand_frame(txb);
      b_fok = fok_cnt;
      b_ovr = ovr_cnt;
      send_frame(txq, 1'b1);
      wait_busy();
      send_frame(txb, 1'b1);
      nf += 2;
      wait_frames(nf);
      check_both("backA", nf - 2, txq);
      check_both("backB", nf - 1, txb);
      check("back_frame_ok", 64'(fok_cnt - b_fok), 64'd2);
      check("back_overrun", 64'(ovr_cnt - b_ovr), 64'd0);

      // A start frame while B is still pending discards B.
      rand_frame(txq);
      rand_frame(txb);
      b_fok = fok_cnt;
      b_ovr = ovr_cnt;
      send_frame(txq, 1'b1);
      wait_busy();
      send_frame(txb, 1'b1);
      send_word(32'h0);
      nf++;
      wait_frames(nf);
      repeat (300) @(negedge clk);
      check_both("ovrA", nf - 1, txq);
      check("ovr_pulse", 64'(ovr_cnt - b_ovr), 64'd1);
      check("ovr_frame_ok", 64'(fok_cnt - b_fok), 64'd1);
      check("ovr_no_commit", 64'(fq0.size()), 64'(nf));

      // Asynchronous reset in the middle of a high phase of pixel 3.
      rand_frame(txq);
      send_frame(txq, 1'b0);
      wait_busy();
      tgt = rise_cyc + 3 * 24 * PTBIT + 3;
      t = 0;
      while (cyc < tgt && t < 10000) begin
         @(negedge clk);
         t++;
      end
      check("mid_high_led", 64'(bus0.led_o), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("async_led", 64'(bus0.led_o), 64'd0);
      check("async_busy", 64'(bus0.busy), 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      b_busy = busy_cnt;
      b_fq = fq0.size();
      repeat (2000) @(negedge clk);
      check("post_rst_idle", 64'(busy_cnt - b_busy), 64'd0);
      check("post_rst_frames", 64'(fq0.size()), 64'(b_fq));
      rand_frame(txq);
      send_frame(txq, 1'b1);
      nf++;
      wait_frames(nf);
      check_both("post_rst", nf - 1, txq);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
